shuffle_buffer: RTL and testbench

- Holds up to `bs` data entries and publishes their occupancy as a candidate bitmap for the random-selection stage.
- Accepts the buffer index chosen by that stage, reads the entry out, and frees the slot.
- Sits around the selector: upstream of it for `cand_list`, downstream of it for the returned index.
- Supports a drain mode that empties the buffer in index order, bypassing random selection.

---
 rtl/shuffle_buffer.sv | 230 +++++++++++++++++++++++
 tb/tb_shuffle_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/shuffle_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : shuffle_buffer
//  Purpose  : Holds up to bs data entries for a random-selection stage.
//             Occupancy is published as a candidate bitmap (cand_list). The
//             selector returns an index, and the entry at that index is read
//             out and freed. A flush pulse starts drain mode, which empties
//             the buffer in ascending index order and ignores the selector.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             in_valid/in_data      - write request and write data
//             in_ready              - write can be accepted (RUN and not full)
//             cand_list             - registered occupancy bitmap
//             sel_index/pop_req     - selector index and pop request
//             flush                 - one-cycle pulse, enter drain mode
//             out_valid/out_data/   - registered one-cycle read result and
//             out_index               its source slot
//             count/empty/full      - registered occupancy and flags
//             pop_err               - sticky, set by a pop of an empty slot
//             parity_err            - (SHUFFLE_BUF_PARITY_EN only) pulses with
//                                     out_valid when stored parity mismatches
//  Options  : `define SHUFFLE_BUF_PARITY_EN to store an even-parity bit per
//             entry and check it on every pop.
//  Revision : 1.0 - initial release
// ============================================================================
module shuffle_buffer #(
    parameter  int bs      = 16,
    parameter  int dw      = 32,
    localparam int bs_bits = $clog2(bs)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [dw-1:0]      in_data,
    output logic               in_ready,
    output logic [bs-1:0]      cand_list,
    input  logic [bs_bits-1:0] sel_index,
    input  logic               pop_req,
    input  logic               flush,
    output logic               out_valid,
    output logic [dw-1:0]      out_data,
    output logic [bs_bits-1:0] out_index,
    output logic [bs_bits:0]   count,
    output logic               empty,
    output logic               full,
    output logic               pop_err
`ifdef SHUFFLE_BUF_PARITY_EN
    ,
    output logic               parity_err
`endif
);

    localparam logic [bs_bits:0] c_cnt_one  = (bs_bits+1)'(1);
    localparam logic [bs_bits:0] c_cnt_full = (bs_bits+1)'(bs);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic [dw-1:0]        r_mem [bs];
    logic [bs-1:0]        r_vld;
    logic [bs_bits:0]     r_count;
    logic                 r_full;
    logic                 r_empty;
    logic                 r_out_valid;
    logic [dw-1:0]        r_out_data;
    logic [bs_bits-1:0]   r_out_index;
    logic                 r_pop_err;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic [bs_bits-1:0]   w_free_idx;
    logic [bs_bits-1:0]   w_first_vld;
    logic [bs_bits-1:0]   w_pop_idx;
    logic                 w_in_ready;
    logic                 w_wr;
    logic                 w_sel_vld;
    logic                 w_run_pop;
    logic                 w_pop_miss;
    logic                 w_drain_pop;
    logic                 w_pop;
    logic [bs_bits:0]     w_count_nxt;
    logic [bs-1:0]        w_vld_nxt;

    // Lowest set bit of a vector; returns 0 when no bit is set. Callers only
    // use the result when at least one bit is known to be set.
    function automatic logic [bs_bits-1:0] f_lowest(input logic [bs-1:0] v);
        f_lowest = '0;
        for (int i = bs - 1; i >= 0; i--) begin
            if (v[i]) begin
                f_lowest = bs_bits'(i);
            end
        end
    endfunction

    // Both encoders look at the registered bitmap, i.e. before this cycle's
    // pop takes effect, so a slot freed now cannot be refilled in the same
    // cycle.
    assign w_free_idx  = f_lowest(~r_vld);
    assign w_first_vld = f_lowest(r_vld);

    // No same-cycle bypass: a full buffer refuses writes even while popping.
    assign w_in_ready  = (r_state == ST_RUN) && !r_full;
    assign w_wr        = in_valid && w_in_ready;

    assign w_sel_vld   = r_vld[sel_index];
    assign w_run_pop   = (r_state == ST_RUN) && pop_req && w_sel_vld;
    assign w_pop_miss  = (r_state == ST_RUN) && pop_req && !w_sel_vld;
    assign w_drain_pop = (r_state == ST_DRAIN) && !r_empty;
    assign w_pop       = w_run_pop || w_drain_pop;
    assign w_pop_idx   = (r_state == ST_DRAIN) ? w_first_vld : sel_index;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_pop) begin
            w_count_nxt = r_count + c_cnt_one;
        end else if (!w_wr && w_pop) begin
            w_count_nxt = r_count - c_cnt_one;
        end
    end

    // The write slot is free in r_vld and the pop slot is occupied in r_vld,
    // so the two updates never touch the same bit.
    always_comb begin
        w_vld_nxt = r_vld;
        if (w_pop) begin
            w_vld_nxt[w_pop_idx] = 1'b0;
        end
        if (w_wr) begin
            w_vld_nxt[w_free_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Storage (contents need no reset; validity lives in r_vld)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_free_idx] <= in_data;
        end
    end

`ifdef SHUFFLE_BUF_PARITY_EN
    logic [bs-1:0] r_par;
    logic          r_parity_err;
    logic          w_par_now;

    assign w_par_now = ^r_mem[w_pop_idx];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_par[w_free_idx] <= ^in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_pop && (w_par_now != r_par[w_pop_idx]);
        end
    end

    assign parity_err = r_parity_err;
`endif

    // ------------------------------------------------------------------------
    // Control, FSM and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_vld       <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_pop_err   <= 1'b0;
        end else begin
            r_vld       <= w_vld_nxt;
            r_count     <= w_count_nxt;
            r_full      <= (w_count_nxt == c_cnt_full);
            r_empty     <= (w_count_nxt == '0);
            r_out_valid <= w_pop;
            if (w_pop) begin
                r_out_data  <= r_mem[w_pop_idx];
                r_out_index <= w_pop_idx;
            end
            if (w_pop_miss) begin
                r_pop_err <= 1'b1;
            end

            case (r_state)
                ST_RUN: begin
                    // A pop in the flush cycle is still performed above.
                    if (flush) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Leave on the edge of the last pop, or after one idle
                    // cycle when flushed while already empty.
                    if (r_count <= c_cnt_one) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign cand_list = r_vld;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_index = r_out_index;
    assign count     = r_count;
    assign empty     = r_empty;
    assign full      = r_full;
    assign pop_err   = r_pop_err;

endmodule
`default_nettype wire

// File: tb/tb_shuffle_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shuffle_buffer
//  Purpose  : Directed self-checking bench for shuffle_buffer (bs=16, dw=32).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shuffle_buffer;

    localparam int BS = 16;
    localparam int DW = 32;
    localparam int BB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [BS-1:0] cand_list;
    logic [BB-1:0] sel_index;
    logic          pop_req;
    logic          flush;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [BB-1:0] out_index;
    logic [BB:0]   count;
    logic          empty;
    logic          full;
    logic          pop_err;
`ifdef SHUFFLE_BUF_PARITY_EN
    logic          parity_err;
`endif

    int errors = 0;
    int checks = 0;

    shuffle_buffer #(.bs(BS), .dw(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .cand_list (cand_list),
        .sel_index (sel_index),
        .pop_req   (pop_req),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_index (out_index),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .pop_err   (pop_err)
`ifdef SHUFFLE_BUF_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; sel_index = '0;
        pop_req = 1'b0; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic write_one(input logic [DW-1:0] d);
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_one(input logic [BB-1:0] idx);
        pop_req = 1'b1; sel_index = idx;
        tick();
        pop_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cand_list !== 16'h0000) begin errors++; $display("FAIL reset_cand got=%h exp=0000", cand_list); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags empty=%b full=%b exp 1/0", empty, full); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_index !== 4'd0) begin errors++; $display("FAIL reset_out v=%b d=%h i=%0d exp 0/0/0", out_valid, out_data, out_index); end
        checks++; if (pop_err !== 1'b0) begin errors++; $display("FAIL reset_pop_err got=%b exp=0", pop_err); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            write_one(32'h100 + 32'(i));
        end
        checks++; if (cand_list !== 16'hFFFF) begin errors++; $display("FAIL fill_cand got=%h exp=ffff", cand_list); end
        checks++; if (count !== 5'd16 || full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL fill_count cnt=%0d full=%b empty=%b exp 16/1/0", count, full, empty); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
        write_one(32'hDEAD);
        checks++; if (count !== 5'd16 || cand_list !== 16'hFFFF) begin errors++; $display("FAIL fill_refused cnt=%0d cand=%h exp 16/ffff", count, cand_list); end
    endtask

    // Continues from the full buffer left by test_fill.
    task automatic test_pop_full();
        in_valid = 1'b1; in_data = 32'hBAD;   // refused: full, no bypass
        pop_one(4'd5);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h105 || out_index !== 4'd5) begin errors++; $display("FAIL pop5_out v=%b d=%h i=%0d exp 1/105/5", out_valid, out_data, out_index); end
        checks++; if (cand_list !== 16'hFFDF || count !== 5'd15) begin errors++; $display("FAIL pop5_cand cand=%h cnt=%0d exp ffdf/15", cand_list, count); end
        write_one(32'h555);
        checks++; if (cand_list !== 16'hFFFF || out_valid !== 1'b0) begin errors++; $display("FAIL refill_cand cand=%h v=%b exp ffff/0", cand_list, out_valid); end
        pop_one(4'd5);
        checks++; if (out_data !== 32'h555 || out_index !== 4'd5) begin errors++; $display("FAIL refill_slot d=%h i=%0d exp 555/5", out_data, out_index); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        write_one(32'hA0); write_one(32'hA1); write_one(32'hA2);
        in_valid = 1'b1; in_data = 32'hB3;
        pop_one(4'd1);
        in_valid = 1'b0;
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL simul_count got=%0d exp=3", count); end
        checks++; if (cand_list !== 16'h000D || out_data !== 32'hA1 || out_index !== 4'd1) begin errors++; $display("FAIL simul_slot cand=%h d=%h i=%0d exp 000d/a1/1", cand_list, out_data, out_index); end
        pop_one(4'd3);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hB3 || count !== 5'd2) begin errors++; $display("FAIL simul_pop3 v=%b d=%h cnt=%0d exp 1/b3/2", out_valid, out_data, count); end
    endtask

    task automatic test_pop_err();
        do_reset();
        pop_one(4'd7);
        checks++; if (out_valid !== 1'b0 || pop_err !== 1'b1) begin errors++; $display("FAIL pop_err_set v=%b err=%b exp 0/1", out_valid, pop_err); end
        tick(); tick();
        checks++; if (pop_err !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL pop_err_hold err=%b cnt=%0d exp 1/0", pop_err, count); end
        do_reset();
        checks++; if (pop_err !== 1'b0) begin errors++; $display("FAIL pop_err_clear got=%b exp=0", pop_err); end
    endtask

    task automatic test_drain();
        logic [BS-1:0] keep;
        keep = 16'h4204;   // slots 2, 9, 14
        do_reset();
        for (int i = 0; i < 15; i++) begin
            write_one(32'h200 + 32'(i));
        end
        for (int i = 0; i < 15; i++) begin
            if (!keep[i]) pop_one(BB'(i));
        end
        checks++; if (cand_list !== 16'h4204 || count !== 5'd3) begin errors++; $display("FAIL drain_setup cand=%h cnt=%0d exp 4204/3", cand_list, count); end
        flush = 1'b1; tick(); flush = 1'b0;
        // Writes and selector pops must be ignored while draining.
        in_valid = 1'b1; in_data = 32'hFEED; pop_req = 1'b1; sel_index = 4'd0;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_d1 rdy=%b v=%b exp 0/0", in_ready, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd2 || out_data !== 32'h202 || in_ready !== 1'b0) begin errors++; $display("FAIL drain_2 v=%b i=%0d d=%h rdy=%b exp 1/2/202/0", out_valid, out_index, out_data, in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd9 || out_data !== 32'h209 || in_ready !== 1'b0) begin errors++; $display("FAIL drain_9 v=%b i=%0d d=%h rdy=%b exp 1/9/209/0", out_valid, out_index, out_data, in_ready); end
        tick();
        in_valid = 1'b0; pop_req = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd14 || out_data !== 32'h20E) begin errors++; $display("FAIL drain_14 v=%b i=%0d d=%h exp 1/14/20e", out_valid, out_index, out_data); end
        checks++; if (empty !== 1'b1 || in_ready !== 1'b1 || cand_list !== 16'h0 || pop_err !== 1'b0) begin errors++; $display("FAIL drain_done empty=%b rdy=%b cand=%h err=%b exp 1/1/0000/0", empty, in_ready, cand_list, pop_err); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_after v=%b exp=0", out_valid); end
        // Flush of an empty buffer: one idle DRAIN cycle, then RUN.
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty_d rdy=%b v=%b exp 0/0", in_ready, out_valid); end
        tick();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty_run rdy=%b v=%b exp 1/0", in_ready, out_valid); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            write_one(32'h300 + 32'(i));
        end
        flush = 1'b1; tick(); flush = 1'b0;
        tick();   // second drain cycle, first pop result visible
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd0) begin errors++; $display("FAIL mid_drain_pre v=%b i=%0d exp 1/0", out_valid, out_index); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (cand_list !== 16'h0 || count !== 5'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_drain_rst cand=%h cnt=%0d v=%b rdy=%b exp 0000/0/0/1", cand_list, count, out_valid, in_ready); end
        write_one(32'h777);
        checks++; if (cand_list !== 16'h0001 || count !== 5'd1) begin errors++; $display("FAIL mid_drain_run cand=%h cnt=%0d exp 0001/1", cand_list, count); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; sel_index = '0;
        pop_req = 1'b0; flush = 1'b0;
        test_reset();
        test_fill();
        test_pop_full();
        test_back_to_back();
        test_pop_err();
        test_drain();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
